// File: rtl/irrigation_decoder.sv
// irrigation_decoder: sync, debounce and interlock the 2-bit irrigation code into valve drives
module irrigation_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEAD_CYCLES   = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] irrigation_encoded,
  output logic       dripper_valve,
  output logic       splinker_valve,
  output logic [1:0] mode_code,
  output logic       busy,
  output logic       fault
);
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int DW = $clog2(DEAD_CYCLES) + 1;
  localparam logic [SW-1:0] S_MAX  = SW'(STABLE_CYCLES);
  localparam logic [DW-1:0] D_LOAD = DW'(DEAD_CYCLES);
  typedef enum logic [2:0] {OFF, DRIP, SPLK, DEAD, FAULT} state_t;
  logic [1:0]    sync1, sync2, cand, accepted;
  logic [SW-1:0] stab_cnt, run_len;
  logic [DW-1:0] dead_cnt, dead_next;
  state_t        state, next_state;
  function automatic state_t mode_of(input logic [1:0] c);
    return c == 2'b10 ? DRIP : c == 2'b01 ? SPLK : OFF;
  endfunction
  // two-flop synchronizer on both code bits
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= irrigation_encoded;
      sync2 <= sync1;
    end
  // length of the current run of the synchronized code, counting this cycle
  always_comb run_len = (sync2 != cand) ? SW'(1) : (stab_cnt < S_MAX ? stab_cnt + SW'(1) : S_MAX);
  // debounce: accept the code once it has been seen for STABLE_CYCLES consecutive cycles
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cand     <= 2'b00;
      stab_cnt <= '0;
      accepted <= 2'b00;
    end else begin
      cand     <= sync2;
      stab_cnt <= run_len;
      if (run_len >= S_MAX) accepted <= sync2;
    end
  // mode FSM: invalid code wins everywhere, direct switchovers pass through DEAD
  always_comb begin
    next_state = state;
    dead_next  = dead_cnt;
    case (state)
      OFF:   next_state = accepted == 2'b11 ? FAULT : mode_of(accepted);
      DRIP: begin
        next_state = accepted == 2'b11 ? FAULT : accepted == 2'b00 ? OFF : accepted == 2'b01 ? DEAD : DRIP;
        dead_next  = accepted == 2'b01 ? D_LOAD : dead_cnt;
      end
      SPLK: begin
        next_state = accepted == 2'b11 ? FAULT : accepted == 2'b00 ? OFF : accepted == 2'b10 ? DEAD : SPLK;
        dead_next  = accepted == 2'b10 ? D_LOAD : dead_cnt;
      end
      DEAD: begin
        next_state = accepted == 2'b11 ? FAULT : dead_cnt <= DW'(1) ? mode_of(accepted) : DEAD;
        dead_next  = dead_cnt != '0 ? dead_cnt - DW'(1) : '0;
      end
      FAULT: next_state = accepted == 2'b00 ? OFF : FAULT;
      default: next_state = OFF;
    endcase
  end
  // state, dead-time counter and registered outputs decoded from the next state
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state          <= OFF;
      dead_cnt       <= '0;
      dripper_valve  <= 1'b0;
      splinker_valve <= 1'b0;
      mode_code      <= 2'b00;
      busy           <= 1'b0;
      fault          <= 1'b0;
    end else begin
      state          <= next_state;
      dead_cnt       <= dead_next;
      dripper_valve  <= next_state == DRIP;
      splinker_valve <= next_state == SPLK;
      mode_code      <= next_state == DRIP ? 2'b10 : next_state == SPLK ? 2'b01 : 2'b00;
      busy           <= next_state == DEAD;
      fault          <= next_state == FAULT;
    end
endmodule

// File: tb/tb_irrigation_decoder.sv
// tb_irrigation_decoder: randomized scoreboard bench against a cycle-level behavioural model
module tb_irrigation_decoder;
  localparam int S = 4;
  localparam int D = 8;
  localparam int M_OFF = 0, M_DRIP = 1, M_SPLK = 2, M_DEAD = 3, M_FAULT = 4;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] irrigation_encoded = 2'b00;
  logic       dripper_valve, splinker_valve, busy, fault;
  logic [1:0] mode_code;
  logic [5:0] exp_q[$];
  int         hist[$];
  int         m_state, dead_left, acc;
  int         checks = 0, errors = 0;
  irrigation_decoder #(.STABLE_CYCLES(S), .DEAD_CYCLES(D)) dut (
    .clock(clock), .reset_n(reset_n), .irrigation_encoded(irrigation_encoded),
    .dripper_valve(dripper_valve), .splinker_valve(splinker_valve),
    .mode_code(mode_code), .busy(busy), .fault(fault)
  );
  always #5 clock = ~clock;
  function automatic int in_at(int j);
    return j >= 1 ? hist[j-1] : 0;
  endfunction
  function automatic int mode_for(int code);
    if (code == 2) return M_DRIP;
    if (code == 1) return M_SPLK;
    return M_OFF;
  endfunction
  function automatic logic [5:0] view(int m);
    logic [5:0] v;
    v = 6'b0;
    if (m == M_DRIP) v = 6'b10_10_00;
    if (m == M_SPLK) v = 6'b01_01_00;
    if (m == M_DEAD) v = 6'b00_00_10;
    if (m == M_FAULT) v = 6'b00_00_01;
    return v;
  endfunction
  task automatic model_reset();
    hist.delete();
    m_state = M_OFF;
    dead_left = 0;
    acc = 0;
  endtask
  task automatic model_edge(input int code);
    int k, v;
    bit steady;
    hist.push_back(code);
    k = hist.size();
    if (m_state == M_FAULT) begin
      if (acc == 0) m_state = M_OFF;
    end else if (acc == 3) m_state = M_FAULT;
    else if (m_state == M_DEAD) begin
      if (dead_left == 1) m_state = mode_for(acc);
      dead_left = dead_left - 1;
    end else if (m_state == M_OFF) m_state = mode_for(acc);
    else if (acc == 0) m_state = M_OFF;
    else if (mode_for(acc) != m_state) begin
      m_state = M_DEAD;
      dead_left = D;
    end
    v = in_at(k - 2);
    steady = 1'b1;
    for (int j = k - 2; j >= k - 1 - S; j--) if (in_at(j) != v) steady = 1'b0;
    if (steady) acc = v;
  endtask
  task automatic cycle(input logic [1:0] code);
    irrigation_encoded = code;
    @(posedge clock);
    model_edge(int'(code));
    exp_q.push_back(view(m_state));
    #2;
  endtask
  task automatic hold(input logic [1:0] code, input int n);
    for (int i = 0; i < n; i++) cycle(code);
  endtask
  task automatic do_reset();
    #4;
    reset_n = 1'b0;
    model_reset();
    exp_q.push_back(6'b0);
    @(negedge clock);
    #1;
    @(negedge clock);
    #1;
    reset_n = 1'b1;
  endtask
  // monitor: every cycle the DUT presents its outputs; pop the expected image and compare
  initial begin
    logic [5:0] act, e;
    forever begin
      @(negedge clock);
      act = {dripper_valve, splinker_valve, mode_code, busy, fault};
      checks++;
      if (dripper_valve & splinker_valve) begin
        errors++;
        $display("FAIL interlock t=%0t: valves %b%b, required never both 1", $time, dripper_valve, splinker_valve);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got drip,splk,mode,busy,fault=%b expected %b", $time, act, e);
        end
      end
    end
  end
  initial begin
    int r, len;
    logic [1:0] code;
    model_reset();
    @(posedge clock);
    #2;
    do_reset();
    hold(2'b00, 4);
    hold(2'b10, 12);
    hold(2'b00, 10);
    hold(2'b01, 3);
    hold(2'b00, 10);
    hold(2'b01, 4);
    hold(2'b00, 12);
    hold(2'b10, 12);
    hold(2'b01, 20);
    hold(2'b10, 12);
    hold(2'b01, 6);
    hold(2'b10, 20);
    hold(2'b01, 15);
    hold(2'b11, 10);
    hold(2'b10, 10);
    hold(2'b00, 12);
    hold(2'b10, 15);
    hold(2'b01, 9);
    do_reset();
    hold(2'b01, 15);
    for (int s = 0; s < 150; s++) begin
      r = $urandom_range(0, 19);
      code = r < 5 ? 2'b00 : r < 11 ? 2'b10 : r < 17 ? 2'b01 : 2'b11;
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 24) == 0) do_reset();
      hold(code, len);
    end
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
